// File: rtl/fc_serial_classifier.sv
// rtl/fc_serial_classifier.sv - sequential fully-connected classifier with argmax
//
// Accepts N_IN unsigned activations, one per handshake. Each one is multiplied by
// NUM_CLASS signed weights read from an external ROM with 1-cycle latency. The
// products are summed into NUM_CLASS signed accumulators. A sequential argmax then
// picks the winning class index.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin an inference (only honoured in IDLE)
//   act_valid/act_ready/act_data   activation handshake (ready only in MAC)
//   wt_addr       weight ROM address (current activation index)
//   wt_data       NUM_CLASS packed signed weights, class c at [c*WT_W +: WT_W]
//   busy          high whenever not IDLE
//   result        winning class, 4'hF when no result is available
//   result_valid  one-cycle pulse when result updates
module fc_serial_classifier #(
    parameter int N_IN      = 1152,
    parameter int NUM_CLASS = 10,
    parameter int ACT_W     = 69,
    parameter int WT_W      = 32,
    parameter int ACC_W     = 113,
    parameter int IDX_W     = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      act_valid,
    input  logic [ACT_W-1:0]          act_data,
    output logic                      act_ready,
    output logic [IDX_W-1:0]          wt_addr,
    input  logic [NUM_CLASS*WT_W-1:0] wt_data,
    output logic                      busy,
    output logic [3:0]                result,
    output logic                      result_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_ARGMAX,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0]               cls_q, cls_d;
    logic signed [ACC_W-1:0]  best_q, best_d;
    logic [3:0]               bi_q, bi_d;
    logic [3:0]               result_q, result_d;
    logic                     rv_q, rv_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_CLASS];
    logic signed [ACC_W-1:0]  acc_d [NUM_CLASS];

    // Running maximum seen by the current compare; on the first argmax cycle
    // the running maximum is class 0 itself.
    logic signed [ACC_W-1:0]  cmp_best;
    logic [3:0]               cmp_bi;

    assign act_ready    = (state_q == S_MAC);
    assign busy         = (state_q != S_IDLE);
    assign wt_addr      = idx_q;
    assign result       = result_q;
    assign result_valid = rv_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cls_d    = cls_q;
        best_d   = best_q;
        bi_d     = bi_q;
        result_d = result_q;
        rv_d     = 1'b0;
        acc_d    = acc_q;
        cmp_best = (cls_q == 4'd1) ? acc_q[0] : best_q;
        cmp_bi   = (cls_q == 4'd1) ? 4'd0 : bi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int c = 0; c < NUM_CLASS; c++) begin
                        acc_d[c] = '0;
                    end
                    idx_d    = '0;
                    result_d = 4'hF;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                // wt_addr already presents idx; one cycle lets the ROM answer.
                state_d = S_MAC;
            end
            S_MAC: begin
                if (act_valid) begin
                    // Activation is zero-extended to signed; both operands are
                    // widened to ACC_W so the sum wraps modulo 2^ACC_W.
                    for (int c = 0; c < NUM_CLASS; c++) begin
                        acc_d[c] = acc_q[c]
                                 + (ACC_W'($signed({1'b0, act_data}))
                                 *  ACC_W'($signed(wt_data[c*WT_W +: WT_W])));
                    end
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        cls_d   = 4'd1;
                        state_d = S_ARGMAX;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_ARGMAX: begin
                // Strict compare keeps the lowest index on ties.
                if (acc_q[cls_q] > cmp_best) begin
                    best_d = acc_q[cls_q];
                    bi_d   = cls_q;
                end else begin
                    best_d = cmp_best;
                    bi_d   = cmp_bi;
                end
                if (cls_q == 4'(NUM_CLASS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cls_d = cls_q + 4'd1;
                end
            end
            S_DONE: begin
                result_d = bi_q;
                rv_d     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cls_q    <= 4'd1;
            best_q   <= '0;
            bi_q     <= 4'd0;
            result_q <= 4'hF;
            rv_q     <= 1'b0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cls_q    <= cls_d;
            best_q   <= best_d;
            bi_q     <= bi_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            for (int c = 0; c < NUM_CLASS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

endmodule

// File: tb/tb_fc_serial_classifier.sv
// tb/tb_fc_serial_classifier.sv - self-checking bench for fc_serial_classifier
module tb_fc_serial_classifier;

    localparam int N_IN      = 1152;
    localparam int NUM_CLASS = 10;
    localparam int ACT_W     = 69;
    localparam int WT_W      = 32;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic                      act_valid = 1'b0;
    logic [ACT_W-1:0]          act_data = '0;
    logic                      act_ready;
    logic [10:0]               wt_addr;
    logic [NUM_CLASS*WT_W-1:0] wt_data = '0;
    logic                      busy;
    logic [3:0]                result;
    logic                      result_valid;

    fc_serial_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .act_valid    (act_valid),
        .act_data     (act_data),
        .act_ready    (act_ready),
        .wt_addr      (wt_addr),
        .wt_data      (wt_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cur_mode = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [3:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic signed [WT_W-1:0] wt_fn(input int mode, input int addr, input int c);
        case (mode)
            1: return 0;
            2: return (c == 7) ? 1 : 0;
            3: return (c == 3 || c == 5) ? 2 : -1;
            4: return (c == 9) ? 0 : -1;
            5: return ((addr * 7 + c * 13) % 11) - 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [ACT_W-1:0] act_fn(input int mode, input int i);
        logic [ACT_W-1:0] ones;
        ones = '1;
        case (mode)
            1: return ACT_W'((i * 12345) % 1000);
            2: return ACT_W'(1);
            3: return ACT_W'(5);
            4: return ones;
            5: return ACT_W'((i * 37) % 251);
            default: return '0;
        endcase
    endfunction

    // Reference argmax for the address-dependent weight set (small values fit longint).
    function automatic logic [3:0] model_mode5();
        longint s [NUM_CLASS];
        logic [3:0] bi;
        for (int c = 0; c < NUM_CLASS; c++) s[c] = 0;
        for (int i = 0; i < N_IN; i++)
            for (int c = 0; c < NUM_CLASS; c++)
                s[c] += longint'(act_fn(5, i)) * longint'(wt_fn(5, i, c));
        bi = 0;
        for (int c = 1; c < NUM_CLASS; c++)
            if (s[c] > s[bi]) bi = 4'(c);
        return bi;
    endfunction

    // Weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CLASS; c++)
            wt_data[c*WT_W +: WT_W] <= wt_fn(cur_mode, int'(wt_addr), c);
    end

    always @(posedge clk) begin
        cyc++;
        if (act_valid && act_ready) begin
            acc_cnt++;
            last_acc = cyc;
        end
    end

    task automatic run(input int mode, input int duty, input int abort_at,
                       input bit mid_start, input logic [3:0] exp);
        bit hs;
        int guard;
        bit got;
        logic [3:0] e;
        cur_mode = mode;
        acc_cnt  = 0;
        if (abort_at < 0) exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("result_cleared", result, 4'hF);
        check_eq("ready_in_fetch", act_ready, 0);
        for (int i = 0; i < N_IN; i++) begin
            if (i == abort_at) begin
                @(negedge clk);
                act_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("abort_accepts", acc_cnt, abort_at);
                check_eq("abort_result", result, 4'hF);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_ready", act_ready, 0);
                return;
            end
            hs = 0;
            guard = 0;
            while (!hs && guard < 200) begin
                @(negedge clk);
                act_valid = (duty >= 100) || ($urandom_range(0, 99) < duty);
                act_data  = act_fn(mode, i);
                start     = mid_start && (i == 300);
                hs        = act_valid && act_ready;
                guard++;
            end
            if (!hs) begin
                check_eq("handshake_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        act_valid = 1'b0;
        start     = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (result_valid) got = 1;
            else @(negedge clk);
        end
        check_eq("result_valid_seen", got, 1);
        if (got) begin
            e = exp_q.pop_front();
            check_eq("result", result, e);
            check_eq("latency", cyc - last_acc, NUM_CLASS);
            check_eq("accept_count", acc_cnt, N_IN);
            check_eq("busy_at_valid", busy, 0);
            @(negedge clk);
            check_eq("valid_one_cycle", result_valid, 0);
            check_eq("result_held", result, e);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_act_ready", act_ready, 0);
        check_eq("rst_wt_addr", wt_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", result, 4'hF);
        check_eq("rst_result_valid", result_valid, 0);

        run(1, 100, -1, 0, 4'd0);
        run(2, 100, -1, 0, 4'd7);
        run(3, 100, -1, 0, 4'd3);
        run(4, 100, -1, 0, 4'd9);
        run(2, 30, -1, 0, 4'd7);
        run(2, 100, 500, 0, 4'd0);
        run(2, 100, -1, 1, 4'd7);
        run(5, 70, -1, 0, model_mode5());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        check_eq("global_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
